// File: rtl/axi_ram_cmd_arb_mux.sv
// axi_ram_cmd_arb_mux: round-robin merge of PORTS RAM command streams with in-order read-response routing.
// Define AXI_RAM_CMD_ARB_STAT_EN to add per-port saturating accepted-beat counters.
module axi_ram_cmd_arb_mux #(
    parameter int PORTS          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH/8,
    parameter int ID_WIDTH       = 8,
    parameter int INTERLEAVE     = 0,
    parameter int TAG_FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef AXI_RAM_CMD_ARB_STAT_EN
    input  logic                        stat_clear,
    output logic [PORTS*16-1:0]         stat_beats,
`endif
    input  logic [PORTS*ID_WIDTH-1:0]   s_cmd_id,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] s_cmd_wr_data,
    input  logic [PORTS*STRB_WIDTH-1:0] s_cmd_wr_strb,
    input  logic [PORTS-1:0]            s_cmd_wr_en,
    input  logic [PORTS-1:0]            s_cmd_rd_en,
    input  logic [PORTS-1:0]            s_cmd_last,
    output logic [PORTS-1:0]            s_cmd_ready,
    output logic [PORTS*ID_WIDTH-1:0]   s_rd_resp_id,
    output logic [PORTS*DATA_WIDTH-1:0] s_rd_resp_data,
    output logic [PORTS-1:0]            s_rd_resp_last,
    output logic [PORTS-1:0]            s_rd_resp_valid,
    input  logic [PORTS-1:0]            s_rd_resp_ready,
    output logic [ID_WIDTH-1:0]         m_cmd_id,
    output logic [ADDR_WIDTH-1:0]       m_cmd_addr,
    output logic [DATA_WIDTH-1:0]       m_cmd_wr_data,
    output logic [STRB_WIDTH-1:0]       m_cmd_wr_strb,
    output logic                        m_cmd_wr_en,
    output logic                        m_cmd_rd_en,
    output logic                        m_cmd_last,
    input  logic                        m_cmd_ready,
    input  logic [ID_WIDTH-1:0]         m_rd_resp_id,
    input  logic [DATA_WIDTH-1:0]       m_rd_resp_data,
    input  logic                        m_rd_resp_last,
    input  logic                        m_rd_resp_valid,
    output logic                        m_rd_resp_ready
);
    localparam int PW = $clog2(PORTS);
    localparam int TW = $clog2(TAG_FIFO_DEPTH);

    logic [PW-1:0]    rr_q, rr_d, grant_q, grant_d, win, head;
    logic             locked_q, locked_d, win_vld, tag_full, tag_empty, beat, push, pop;
    logic [PORTS-1:0] req;
    logic [TW:0]      cnt_q, cnt_d;
    logic [TW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [PW-1:0]    tag_q [TAG_FIFO_DEPTH];
    logic [PW-1:0]    tag_d [TAG_FIFO_DEPTH];
    int               k;

    assign tag_full  = cnt_q == (TW+1)'(TAG_FIFO_DEPTH);
    assign tag_empty = cnt_q == '0;
    // a read-only request is withheld while every tag slot is in use
    assign req = s_cmd_wr_en | (s_cmd_rd_en & {PORTS{!tag_full}});

    // scanning downwards leaves the first requester at or after rr_q as the winner
    always_comb begin
        win     = grant_q;
        win_vld = locked_q && req[grant_q];
        k       = 0;
        if (!locked_q) begin
            for (int j = PORTS-1; j >= 0; j--) begin
                k = (int'(rr_q) + j) % PORTS;
                if (req[k]) begin
                    win     = PW'(k);
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_cmd_ready      = '0;
        s_cmd_ready[win] = rst_n && win_vld && m_cmd_ready;
    end

    assign m_cmd_id      = s_cmd_id[win*ID_WIDTH +: ID_WIDTH];
    assign m_cmd_addr    = s_cmd_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_cmd_wr_data = s_cmd_wr_data[win*DATA_WIDTH +: DATA_WIDTH];
    assign m_cmd_wr_strb = s_cmd_wr_strb[win*STRB_WIDTH +: STRB_WIDTH];
    assign m_cmd_last    = s_cmd_last[win];
    assign m_cmd_wr_en   = rst_n && win_vld && s_cmd_wr_en[win];
    assign m_cmd_rd_en   = rst_n && win_vld && !s_cmd_wr_en[win] && s_cmd_rd_en[win];
    assign beat          = m_cmd_ready && (m_cmd_wr_en || m_cmd_rd_en);

    always_comb begin
        grant_d  = beat ? win : grant_q;
        locked_d = beat ? (INTERLEAVE == 0) && !m_cmd_last : locked_q;
        rr_d     = (beat && !locked_d) ? ((win == PW'(PORTS-1)) ? '0 : win + 1'b1) : rr_q;
    end

    assign push = beat && m_cmd_rd_en;
    assign pop  = m_rd_resp_valid && m_rd_resp_ready;
    assign wp_d = push ? wp_q + 1'b1 : wp_q;
    assign rp_d = pop ? rp_q + 1'b1 : rp_q;
    assign cnt_d = cnt_q + (TW+1)'(push) - (TW+1)'(pop);

    always_comb begin
        tag_d = tag_q;
        if (push) tag_d[wp_q] = win;
    end

    assign head = tag_q[rp_q];

    always_comb begin
        s_rd_resp_valid       = '0;
        s_rd_resp_valid[head] = !tag_empty && m_rd_resp_valid;
    end

    assign m_rd_resp_ready = !tag_empty && s_rd_resp_ready[head];
    assign s_rd_resp_id    = {PORTS{m_rd_resp_id}};
    assign s_rd_resp_data  = {PORTS{m_rd_resp_data}};
    assign s_rd_resp_last  = {PORTS{m_rd_resp_last}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            for (int i = 0; i < TAG_FIFO_DEPTH; i++) tag_q[i] <= '0;
        end else begin
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            tag_q    <= tag_d;
        end
    end

`ifdef AXI_RAM_CMD_ARB_STAT_EN
    logic [15:0] stat_q [PORTS];
    logic [15:0] stat_d [PORTS];

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            stat_d[i] = stat_clear ? 16'h0 : stat_q[i] + 16'(beat && win == PW'(i) && stat_q[i] != 16'hFFFF);
            stat_beats[i*16 +: 16] = stat_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORTS; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end
`endif
endmodule

// File: tb/tb_axi_ram_cmd_arb_mux.sv
// tb_axi_ram_cmd_arb_mux: randomized self-checking bench for the RAM command arbiter.
// Burst-atomic and beat-interleaved instances share stimulus; sel picks the one under check.
module tb_axi_ram_cmd_arb_mux;
    localparam int P = 4, DW = 32, AW = 16, SW = 4, IW = 8;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [IW-1:0] id;
        bit            wr;
        bit            last;
    } beat_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [P*IW-1:0] s_cmd_id;
    logic [P*AW-1:0] s_cmd_addr;
    logic [P*DW-1:0] s_cmd_wr_data;
    logic [P*SW-1:0] s_cmd_wr_strb;
    logic [P-1:0]    s_cmd_wr_en, s_cmd_rd_en, s_cmd_last, s_rd_resp_ready;
    logic            m_cmd_ready, m_rd_resp_last, m_rd_resp_valid, stat_clear;
    logic [IW-1:0]   m_rd_resp_id;
    logic [DW-1:0]   m_rd_resp_data;

    logic [P-1:0]    s_cmd_ready, i_s_cmd_ready, s_rd_resp_last, i_s_rd_resp_last;
    logic [P-1:0]    s_rd_resp_valid, i_s_rd_resp_valid;
    logic [P*IW-1:0] s_rd_resp_id, i_s_rd_resp_id;
    logic [P*DW-1:0] s_rd_resp_data, i_s_rd_resp_data;
    logic [IW-1:0]   m_cmd_id, i_m_cmd_id;
    logic [AW-1:0]   m_cmd_addr, i_m_cmd_addr;
    logic [DW-1:0]   m_cmd_wr_data, i_m_cmd_wr_data;
    logic [SW-1:0]   m_cmd_wr_strb, i_m_cmd_wr_strb;
    logic            m_cmd_wr_en, i_m_cmd_wr_en, m_cmd_rd_en, i_m_cmd_rd_en;
    logic            m_cmd_last, i_m_cmd_last, m_rd_resp_ready, i_m_rd_resp_ready;
`ifdef AXI_RAM_CMD_ARB_STAT_EN
    logic [P*16-1:0] stat_beats, i_stat_beats;
`endif

    bit            sel;
    int            nchk = 0, nfail = 0, m_ptr = 0;
    int            acc_q[$];
    beat_t         pq[P][$];
    beat_t         exp_q[$];
    logic [P-1:0]  c_ready;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [SW-1:0] c_strb;
    logic [IW-1:0] c_id;
    logic          c_wr, c_rd, c_last;

    assign c_ready = sel ? i_s_cmd_ready : s_cmd_ready;
    assign c_addr  = sel ? i_m_cmd_addr : m_cmd_addr;
    assign c_data  = sel ? i_m_cmd_wr_data : m_cmd_wr_data;
    assign c_strb  = sel ? i_m_cmd_wr_strb : m_cmd_wr_strb;
    assign c_id    = sel ? i_m_cmd_id : m_cmd_id;
    assign c_wr    = sel ? i_m_cmd_wr_en : m_cmd_wr_en;
    assign c_rd    = sel ? i_m_cmd_rd_en : m_cmd_rd_en;
    assign c_last  = sel ? i_m_cmd_last : m_cmd_last;

    axi_ram_cmd_arb_mux #(.PORTS(P), .INTERLEAVE(0), .TAG_FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AXI_RAM_CMD_ARB_STAT_EN
        .stat_clear(stat_clear), .stat_beats(stat_beats),
`endif
        .s_cmd_id(s_cmd_id), .s_cmd_addr(s_cmd_addr), .s_cmd_wr_data(s_cmd_wr_data),
        .s_cmd_wr_strb(s_cmd_wr_strb), .s_cmd_wr_en(s_cmd_wr_en), .s_cmd_rd_en(s_cmd_rd_en),
        .s_cmd_last(s_cmd_last), .s_cmd_ready(s_cmd_ready), .s_rd_resp_id(s_rd_resp_id),
        .s_rd_resp_data(s_rd_resp_data), .s_rd_resp_last(s_rd_resp_last),
        .s_rd_resp_valid(s_rd_resp_valid), .s_rd_resp_ready(s_rd_resp_ready),
        .m_cmd_id(m_cmd_id), .m_cmd_addr(m_cmd_addr), .m_cmd_wr_data(m_cmd_wr_data),
        .m_cmd_wr_strb(m_cmd_wr_strb), .m_cmd_wr_en(m_cmd_wr_en), .m_cmd_rd_en(m_cmd_rd_en),
        .m_cmd_last(m_cmd_last), .m_cmd_ready(m_cmd_ready), .m_rd_resp_id(m_rd_resp_id),
        .m_rd_resp_data(m_rd_resp_data), .m_rd_resp_last(m_rd_resp_last),
        .m_rd_resp_valid(m_rd_resp_valid), .m_rd_resp_ready(m_rd_resp_ready)
    );

    axi_ram_cmd_arb_mux #(.PORTS(P), .INTERLEAVE(1), .TAG_FIFO_DEPTH(16)) dut_i (
        .clk(clk), .rst_n(rst_n),
`ifdef AXI_RAM_CMD_ARB_STAT_EN
        .stat_clear(stat_clear), .stat_beats(i_stat_beats),
`endif
        .s_cmd_id(s_cmd_id), .s_cmd_addr(s_cmd_addr), .s_cmd_wr_data(s_cmd_wr_data),
        .s_cmd_wr_strb(s_cmd_wr_strb), .s_cmd_wr_en(s_cmd_wr_en), .s_cmd_rd_en(s_cmd_rd_en),
        .s_cmd_last(s_cmd_last), .s_cmd_ready(i_s_cmd_ready), .s_rd_resp_id(i_s_rd_resp_id),
        .s_rd_resp_data(i_s_rd_resp_data), .s_rd_resp_last(i_s_rd_resp_last),
        .s_rd_resp_valid(i_s_rd_resp_valid), .s_rd_resp_ready(s_rd_resp_ready),
        .m_cmd_id(i_m_cmd_id), .m_cmd_addr(i_m_cmd_addr), .m_cmd_wr_data(i_m_cmd_wr_data),
        .m_cmd_wr_strb(i_m_cmd_wr_strb), .m_cmd_wr_en(i_m_cmd_wr_en), .m_cmd_rd_en(i_m_cmd_rd_en),
        .m_cmd_last(i_m_cmd_last), .m_cmd_ready(m_cmd_ready), .m_rd_resp_id(m_rd_resp_id),
        .m_rd_resp_data(m_rd_resp_data), .m_rd_resp_last(m_rd_resp_last),
        .m_rd_resp_valid(m_rd_resp_valid), .m_rd_resp_ready(i_m_rd_resp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_inputs;
        s_cmd_id = '0; s_cmd_addr = '0; s_cmd_wr_data = '0; s_cmd_wr_strb = '0;
        s_cmd_wr_en = '0; s_cmd_rd_en = '0; s_cmd_last = '0; s_rd_resp_ready = '0;
        m_cmd_ready = 1'b0; m_rd_resp_id = '0; m_rd_resp_data = '0; m_rd_resp_last = 1'b0;
        m_rd_resp_valid = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        m_ptr = 0;
        for (int i = 0; i < P; i++) pq[i].delete();
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_burst(input int p, input int len, input bit wr);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.port = p; x.addr = AW'($urandom); x.data = $urandom; x.strb = SW'($urandom);
            x.id = IW'($urandom); x.wr = wr; x.last = (b == len - 1);
            pq[p].push_back(x);
        end
    endtask

    // Reference order: whole bursts (or single beats when il) served round-robin from m_ptr.
    task automatic build_model(input bit il);
        beat_t tq[P][$];
        beat_t x;
        int left = 0, p;
        for (int i = 0; i < P; i++) begin
            tq[i] = pq[i];
            left += tq[i].size();
        end
        while (left > 0) begin
            p = m_ptr;
            while (tq[p].size() == 0) p = (p + 1) % P;
            do begin
                x = tq[p].pop_front();
                exp_q.push_back(x);
                left--;
            end while (!il && !x.last);
            m_ptr = (p + 1) % P;
        end
    endtask

    task automatic run(input bit rnd, input int maxc);
        beat_t e;
        logic [P-1:0] er;
        int cyc = 0, p;
        while (exp_q.size() > 0 && cyc < maxc) begin
            @(negedge clk);
            for (int i = 0; i < P; i++) begin
                if (pq[i].size() > 0) begin
                    s_cmd_wr_en[i] = pq[i][0].wr;
                    s_cmd_rd_en[i] = pq[i][0].wr ? 1'($urandom_range(0, 1)) : 1'b1;
                    s_cmd_addr[i*AW +: AW] = pq[i][0].addr;
                    s_cmd_wr_data[i*DW +: DW] = pq[i][0].data;
                    s_cmd_wr_strb[i*SW +: SW] = pq[i][0].strb;
                    s_cmd_id[i*IW +: IW] = pq[i][0].id;
                    s_cmd_last[i] = pq[i][0].last;
                end else begin
                    s_cmd_wr_en[i] = 1'b0;
                    s_cmd_rd_en[i] = 1'b0;
                end
            end
            m_cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            e = exp_q[0];
            er = m_cmd_ready ? (P'(1) << e.port) : '0;
            p = -1;
            for (int i = 0; i < P; i++) if (c_ready[i]) p = i;
            nchk++;
            if (c_ready !== er || c_wr !== e.wr || c_rd !== !e.wr || c_addr !== e.addr ||
                c_id !== e.id || c_last !== e.last || (e.wr && (c_data !== e.data || c_strb !== e.strb))) begin
                nfail++;
                $display("FAIL beat: ready %b wr %b rd %b addr %h last %b, expected ready %b wr %b addr %h last %b",
                         c_ready, c_wr, c_rd, c_addr, c_last, er, e.wr, e.addr, e.last);
            end
            if (m_cmd_ready && p >= 0 && pq[p].size() > 0) begin
                acc_q.push_back(p);
                void'(pq[p].pop_front());
                void'(exp_q.pop_front());
            end
            cyc++;
        end
        nchk++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d beats left, expected 0", exp_q.size());
        end
        @(negedge clk);
        s_cmd_wr_en = '0; s_cmd_rd_en = '0;
        exp_q.delete();
        for (int i = 0; i < P; i++) pq[i].delete();
    endtask

    task automatic test_reset;
        sel = 0;
        do_reset();
        @(negedge clk); #1;
        nchk++;
        if (s_cmd_ready !== '0 || m_cmd_wr_en !== 1'b0 || m_cmd_rd_en !== 1'b0 ||
            s_rd_resp_valid !== '0 || m_rd_resp_ready !== 1'b0) begin
            nfail++;
            $display("FAIL reset_idle: ready %b wr %b rd %b rvalid %b rready %b, expected all 0",
                     s_cmd_ready, m_cmd_wr_en, m_cmd_rd_en, s_rd_resp_valid, m_rd_resp_ready);
        end
        rst_n = 1'b0;
        s_cmd_wr_en = '1; m_cmd_ready = 1'b1; m_rd_resp_valid = 1'b1; s_rd_resp_ready = '1;
        #1;
        nchk++;
        if (s_cmd_ready !== '0 || m_cmd_wr_en !== 1'b0 || s_rd_resp_valid !== '0 || m_rd_resp_ready !== 1'b0) begin
            nfail++;
            $display("FAIL reset_held: ready %b wr %b rvalid %b rready %b, expected all 0",
                     s_cmd_ready, m_cmd_wr_en, s_rd_resp_valid, m_rd_resp_ready);
        end
        do_reset();
    endtask

    task automatic check_order(input string name, input int exp_ord[8]);
        bit ok = (acc_q.size() == 8);
        for (int i = 0; i < 8 && ok; i++) if (acc_q[i] != exp_ord[i]) ok = 0;
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got ports %p, expected %p", name, acc_q, exp_ord);
        end
    endtask

    task automatic test_grant_order(input bit il);
        sel = il;
        do_reset();
        add_burst(0, 4, 1);
        add_burst(2, 4, 1);
        build_model(il);
        run(0, 50);
        check_order(il ? "interleave_order" : "lock_order", il ? '{0,2,0,2,0,2,0,2} : '{0,0,0,0,2,2,2,2});
        acc_q.delete();
        add_burst(0, 1, 1);
        add_burst(3, 1, 1);
        build_model(il);
        run(0, 10);
        nchk++;
        if (acc_q.size() == 0 || acc_q[0] != 3) begin
            nfail++;
            $display("FAIL rr_after_burst: first port %0d, expected 3", acc_q.size() ? acc_q[0] : -1);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            int rd_left, nb, len;
            bit wr;
            sel = bit'(r % 2);
            do_reset();
            rd_left = 15;
            for (int p = 0; p < P; p++) begin
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, 4);
                    wr = ($urandom_range(0, 2) != 0) || (len > rd_left);
                    if (!wr) rd_left -= len;
                    add_burst(p, len, wr);
                end
            end
            build_model(sel);
            run(1, 500);
        end
    endtask

    task automatic test_tag_full;
        int acc = 0;
        sel = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            s_cmd_rd_en[1] = (acc < 20); s_cmd_last[1] = 1'b1; s_cmd_addr[AW +: AW] = AW'(acc);
            m_cmd_ready = 1'b1;
            #1;
            if (s_cmd_ready[1] && m_cmd_rd_en) acc++;
        end
        nchk++;
        if (acc != 16) begin
            nfail++;
            $display("FAIL tag_full_count: accepted %0d reads, expected 16", acc);
        end
        @(negedge clk);
        s_cmd_wr_en[3] = 1'b1; s_cmd_last[3] = 1'b1;
        #1;
        nchk++;
        if (s_cmd_ready !== 4'b1000 || m_cmd_wr_en !== 1'b1 || m_cmd_rd_en !== 1'b0) begin
            nfail++;
            $display("FAIL tag_full_write: ready %b wr %b rd %b, expected 1000 1 0", s_cmd_ready, m_cmd_wr_en, m_cmd_rd_en);
        end
        @(negedge clk);
        s_cmd_wr_en[3] = 1'b0; m_rd_resp_valid = 1'b1; s_rd_resp_ready = 4'b0010;
        #1;
        nchk++;
        if (m_rd_resp_ready !== 1'b1 || s_rd_resp_valid !== 4'b0010 || s_cmd_ready !== '0) begin
            nfail++;
            $display("FAIL tag_pop: rready %b rvalid %b ready %b, expected 1 0010 0000",
                     m_rd_resp_ready, s_rd_resp_valid, s_cmd_ready);
        end
        @(negedge clk);
        m_rd_resp_valid = 1'b0;
        #1;
        nchk++;
        if (s_cmd_ready !== 4'b0010 || m_cmd_rd_en !== 1'b1) begin
            nfail++;
            $display("FAIL tag_refill: ready %b rd %b, expected 0010 1", s_cmd_ready, m_cmd_rd_en);
        end
        @(negedge clk); #1;
        nchk++;
        if (s_cmd_ready !== '0) begin
            nfail++;
            $display("FAIL tag_full_again: ready %b, expected 0000", s_cmd_ready);
        end
    endtask

    task automatic test_resp_route;
        sel = 0;
        do_reset();
        @(negedge clk);
        s_cmd_rd_en = 4'b1000; s_cmd_last = '1; m_cmd_ready = 1'b1;
        @(negedge clk);
        s_cmd_rd_en = 4'b0001;
        @(negedge clk);
        s_cmd_rd_en = '0;
        m_rd_resp_valid = 1'b1; m_rd_resp_data = 32'hA5A5A5A5; m_rd_resp_id = 8'h33; m_rd_resp_last = 1'b1;
        s_rd_resp_ready = 4'b0001;
        #1;
        nchk++;
        if (s_rd_resp_valid !== 4'b1000 || m_rd_resp_ready !== 1'b0 || s_rd_resp_data[3*DW +: DW] !== 32'hA5A5A5A5) begin
            nfail++;
            $display("FAIL resp_port3_stall: rvalid %b rready %b data %h, expected 1000 0 a5a5a5a5",
                     s_rd_resp_valid, m_rd_resp_ready, s_rd_resp_data[3*DW +: DW]);
        end
        @(negedge clk);
        s_rd_resp_ready = 4'b1000;
        #1;
        nchk++;
        if (m_rd_resp_ready !== 1'b1 || s_rd_resp_valid !== 4'b1000) begin
            nfail++;
            $display("FAIL resp_port3_pop: rready %b rvalid %b, expected 1 1000", m_rd_resp_ready, s_rd_resp_valid);
        end
        @(negedge clk);
        m_rd_resp_data = 32'h5A5A5A5A; m_rd_resp_id = 8'h44; s_rd_resp_ready = 4'b0001;
        #1;
        nchk++;
        if (s_rd_resp_valid !== 4'b0001 || m_rd_resp_ready !== 1'b1 ||
            s_rd_resp_data[0 +: DW] !== 32'h5A5A5A5A || s_rd_resp_id[2*IW +: IW] !== 8'h44 || s_rd_resp_last !== 4'b1111) begin
            nfail++;
            $display("FAIL resp_port0: rvalid %b rready %b data %h id %h last %b, expected 0001 1 5a5a5a5a 44 1111",
                     s_rd_resp_valid, m_rd_resp_ready, s_rd_resp_data[0 +: DW], s_rd_resp_id[2*IW +: IW], s_rd_resp_last);
        end
        @(negedge clk);
        s_rd_resp_ready = '1;
        #1;
        nchk++;
        if (s_rd_resp_valid !== '0 || m_rd_resp_ready !== 1'b0) begin
            nfail++;
            $display("FAIL resp_empty: rvalid %b rready %b, expected 0000 0", s_rd_resp_valid, m_rd_resp_ready);
        end
        m_rd_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        sel = 0;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            s_cmd_wr_en = 4'b0100; s_cmd_last = '0; m_cmd_ready = 1'b1; s_cmd_addr[2*AW +: AW] = AW'(16'h2000 + b);
            #1;
            nchk++;
            if (s_cmd_ready !== 4'b0100) begin
                nfail++;
                $display("FAIL burst_beat%0d: ready %b, expected 0100", b, s_cmd_ready);
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if (s_cmd_ready !== '0 || m_cmd_wr_en !== 1'b0 || m_cmd_rd_en !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid_burst: ready %b wr %b rd %b, expected 0000 0 0", s_cmd_ready, m_cmd_wr_en, m_cmd_rd_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_cmd_wr_en = 4'b0110; s_cmd_last[1] = 1'b1; s_cmd_addr[AW +: AW] = 16'h1111;
        #1;
        nchk++;
        if (s_cmd_ready !== 4'b0010 || m_cmd_addr !== 16'h1111) begin
            nfail++;
            $display("FAIL after_reset_winner: ready %b addr %h, expected 0010 1111", s_cmd_ready, m_cmd_addr);
        end
    endtask

`ifdef AXI_RAM_CMD_ARB_STAT_EN
    task automatic test_stats;
        sel = 0;
        do_reset();
        @(negedge clk);
        s_cmd_wr_en[0] = 1'b1; s_cmd_last[0] = 1'b1; m_cmd_ready = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        nchk++;
        if (stat_beats[15:0] !== 16'd100) begin
            nfail++;
            $display("FAIL stat_count: %0d, expected 100", stat_beats[15:0]);
        end
        repeat (69900) @(negedge clk);
        #1;
        nchk++;
        if (stat_beats[15:0] !== 16'hFFFF || stat_beats[P*16-1:16] !== '0) begin
            nfail++;
            $display("FAIL stat_saturate: %h, expected 0000_0000_0000_ffff", stat_beats);
        end
        @(negedge clk);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0; s_cmd_wr_en = '0;
        #1;
        nchk++;
        if (stat_beats !== '0) begin
            nfail++;
            $display("FAIL stat_clear: %h, expected 0", stat_beats);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_grant_order(0);
        test_grant_order(1);
        test_random();
        test_tag_full();
        test_resp_route();
        test_reset_mid_burst();
`ifdef AXI_RAM_CMD_ARB_STAT_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
